// File: rtl/pcie_rd_req_queue_if.sv
// Request/response bundle between the TLP decoder, the read-request queue and the completion encoder.
// Ports: in_* request capture (valid pulse), out_* head entry with valid/ready, queue status, error flags.
// master = decoder/encoder side (drives requests and ready), slave = the queue itself.
interface pcie_rd_req_queue_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_W      = 3
);
  logic                  in_valid;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [7:0]            in_tag;
  logic [15:0]           in_req_id;
  logic [3:0]            in_be;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [7:0]            out_tag;
  logic [15:0]           out_req_id;
  logic [3:0]            out_be;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic [7:0]            drop_cnt;
  logic                  clr_err;

  modport master (
    output in_valid, in_addr, in_tag, in_req_id, in_be, out_ready, clr_err,
    input  out_valid, out_addr, out_tag, out_req_id, out_be,
           count, full, empty, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_addr, in_tag, in_req_id, in_be, out_ready, clr_err,
    output out_valid, out_addr, out_tag, out_req_id, out_be,
           count, full, empty, overflow, drop_cnt
  );
endinterface

// File: rtl/pcie_rd_req_queue.sv
// Purpose: FIFO of decoded PCIe MRd requests {addr, tag, req_id, be} feeding the completion encoder.
// Latency: 1 cycle push-to-head (first-word-fall-through); one push and one pop per cycle sustained.
// Backpressure: head held stable while out_ready=0; requests arriving when full (and no pop) are dropped,
//   setting sticky overflow and a saturating drop_cnt. Ports: clk, rst (async active-high), q (slave modport).
module pcie_rd_req_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                rst,
  pcie_rd_req_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            tag;
    logic [15:0]           req_id;
    logic [3:0]            be;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [7:0]       drop_q;

  logic   full_w;
  logic   empty_w;
  logic   pop;
  logic   push;
  logic   drop;
  entry_t head;
  entry_t wr_ent;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign pop  = !empty_w && q.out_ready;
  assign push = q.in_valid && (!full_w || pop);
  assign drop = q.in_valid && full_w && !pop;

  assign wr_ent = '{addr: q.in_addr, tag: q.in_tag, req_id: q.in_req_id, be: q.in_be};
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // A drop coinciding with clr_err wins: the new drop is the first one counted.
      if (drop) begin
        overflow_q <= 1'b1;
        if (q.clr_err)            drop_q <= 8'd1;
        else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end else if (q.clr_err) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end
    end
  end

  assign q.out_valid  = !empty_w;
  assign q.out_addr   = head.addr;
  assign q.out_tag    = head.tag;
  assign q.out_req_id = head.req_id;
  assign q.out_be     = head.be;
  assign q.count      = count_q;
  assign q.full       = full_w;
  assign q.empty      = empty_w;
  assign q.overflow   = overflow_q;
  assign q.drop_cnt   = drop_q;
endmodule

// File: tb/tb_pcie_rd_req_queue.sv
`timescale 1ns/1ps
module tb_pcie_rd_req_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int CW    = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    tag;
    logic [15:0]   req_id;
    logic [3:0]    be;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_rd_req_queue_if #(.ADDR_WIDTH(AW), .CNT_W(CW)) rq ();

  pcie_rd_req_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (rq)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: an ordered list of accepted requests plus error counters.
  req_t exp_q[$];
  int   mdl_cnt  = 0;
  bit   mdl_ovf  = 1'b0;
  int   mdl_drop = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic req_t mk(input int addr, input int tag, input int rid, input int be);
    req_t r;
    r.addr   = AW'(addr);
    r.tag    = 8'(tag);
    r.req_id = 16'(rid);
    r.be     = 4'(be);
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk($urandom_range(0, 65535), $urandom_range(0, 255),
              $urandom_range(0, 65535), $urandom_range(0, 15));
  endfunction

  task automatic check_status();
    chk("count",     64'(rq.count),     64'(mdl_cnt));
    chk("out_valid", 64'(rq.out_valid), 64'(mdl_cnt != 0));
    chk("full",      64'(rq.full),      64'(mdl_cnt == DEPTH));
    chk("empty",     64'(rq.empty),     64'(mdl_cnt == 0));
    chk("overflow",  64'(rq.overflow),  64'(mdl_ovf));
    chk("drop_cnt",  64'(rq.drop_cnt),  64'(mdl_drop));
  endtask

  // Called just after a rising edge: drive one cycle, advance the model, check status after the edge.
  task automatic cycle(input bit v, input req_t r, input bit rdy, input bit clr);
    bit pop, push, drop;
    rq.in_valid  = v;
    rq.in_addr   = r.addr;
    rq.in_tag    = r.tag;
    rq.in_req_id = r.req_id;
    rq.in_be     = r.be;
    rq.out_ready = rdy;
    rq.clr_err   = clr;
    pop  = (mdl_cnt > 0) && rdy;
    push = v && ((mdl_cnt < DEPTH) || pop);
    drop = v && !push;
    if (push) exp_q.push_back(r);
    mdl_cnt = mdl_cnt + int'(push) - int'(pop);
    if (drop) begin
      mdl_ovf  = 1'b1;
      mdl_drop = clr ? 1 : ((mdl_drop < 255) ? mdl_drop + 1 : 255);
    end else if (clr) begin
      mdl_ovf  = 1'b0;
      mdl_drop = 0;
    end
    @(posedge clk);
    #1;
    rq.in_valid  = 1'b0;
    rq.in_addr   = $urandom_range(0, 65535);
    rq.in_tag    = $urandom_range(0, 255);
    rq.out_ready = 1'b0;
    rq.clr_err   = 1'b0;
    check_status();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic drain();
    int budget;
    budget = 64;
    while (mdl_cnt > 0 && budget > 0) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      budget--;
    end
    chk("drain_budget", 64'(rq.count), 64'(0));
  endtask

  // Monitor: compares the presented head against the oldest expected request, retires it on handshake,
  // and requires the head fields to stay put across a stalled cycle.
  req_t prev_head;
  bit   hold_prev = 1'b0;
  always @(negedge clk) begin
    req_t cur;
    if (rst) begin
      hold_prev = 1'b0;
    end else if (rq.out_valid) begin
      cur = mk(int'(rq.out_addr), int'(rq.out_tag), int'(rq.out_req_id), int'(rq.out_be));
      if (hold_prev) chk("hold_stable", 64'(cur), 64'(prev_head));
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(rq.out_valid), 64'(0));
      end else begin
        chk("head", 64'(cur), 64'(exp_q[0]));
        if (rq.out_ready) void'(exp_q.pop_front());
      end
      hold_prev = !rq.out_ready;
      prev_head = cur;
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rq.in_valid  = 1'b0;
    rq.in_addr   = '0;
    rq.in_tag    = '0;
    rq.in_req_id = '0;
    rq.in_be     = '0;
    rq.out_ready = 1'b0;
    rq.clr_err   = 1'b0;

    // Reset state with clock running
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(rq.out_valid), 64'(0));
    chk("rst_empty",     64'(rq.empty),     64'(1));
    chk("rst_full",      64'(rq.full),      64'(0));
    chk("rst_count",     64'(rq.count),     64'(0));
    chk("rst_overflow",  64'(rq.overflow),  64'(0));
    chk("rst_drop_cnt",  64'(rq.drop_cnt),  64'(0));
    chk("rst_out_addr",  64'(rq.out_addr),  64'(0));
    chk("rst_out_tag",   64'(rq.out_tag),   64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request, stalled for 5 cycles, then accepted
    cycle(1'b1, mk(16'h0040, 8'h05, 16'h0100, 4'hF), 1'b0, 1'b0);
    chk("single_addr", 64'(rq.out_addr), 64'(16'h0040));
    chk("single_tag",  64'(rq.out_tag),  64'(8'h05));
    idle(5, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Fill, overflow, ordered drain, then clear errors
    for (int t = 1; t <= 4; t++) cycle(1'b1, mk(16'h1000 + t, t, 16'h0200, 4'h3), 1'b0, 1'b0);
    cycle(1'b1, mk(16'h1005, 5, 16'h0200, 4'h3), 1'b0, 1'b0);
    drain();
    idle(2, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Push and pop together while full
    for (int t = 1; t <= 4; t++) cycle(1'b1, mk(16'h2000 + t, t, 16'h0300, 4'h1), 1'b0, 1'b0);
    cycle(1'b1, mk(16'h2009, 9, 16'h0300, 4'h1), 1'b1, 1'b0);
    chk("pp_head_tag", 64'(rq.out_tag), 64'(2));
    drain();

    // Random interleaving across pointer wraps
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), rnd_req(), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Saturating drop counter, then drop racing clr_err
    for (int t = 0; t < 4; t++) cycle(1'b1, rnd_req(), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, rnd_req(), 1'b0, 1'b0);
    chk("sat_drop_cnt", 64'(rq.drop_cnt), 64'(255));
    cycle(1'b1, rnd_req(), 1'b0, 1'b1);
    chk("clr_race_drop_cnt", 64'(rq.drop_cnt), 64'(1));
    cycle(1'b0, '0, 1'b0, 1'b1);
    drain();

    // Asynchronous reset mid-operation
    for (int t = 0; t < 3; t++) cycle(1'b1, rnd_req(), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(rq.out_valid), 64'(0));
    chk("arst_count",     64'(rq.count),     64'(0));
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_ovf  = 1'b0;
    mdl_drop = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, mk(16'h0ABC, 8'h22, 16'h0400, 4'hC), 1'b0, 1'b0);
    chk("post_rst_head_tag", 64'(rq.out_tag), 64'(8'h22));
    idle(1, 1'b0);
    drain();
    idle(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
